// File: rtl/router_ni_pkg.sv
// Shared definitions for the router network-interface injection path:
// flit layout, head-header fields, VC count and the injection FSM state type.
package router_ni_pkg;

  localparam int FLIT_W    = 68;
  localparam int PAYLOAD_W = 64;
  localparam int NUM_VC    = 2;
  localparam int ADDR_W    = 6;
  localparam int LEN_W     = 4;

  localparam int FLIT_VALID       = 0;
  localparam int FLIT_HEAD        = 1;
  localparam int FLIT_TAIL        = 2;
  localparam int FLIT_VC          = 3;
  localparam int FLIT_PAYLOAD_LSB = 4;

  localparam int HDR_DEST_LSB = 0;
  localparam int HDR_SRC_LSB  = 6;
  localparam int HDR_LEN_LSB  = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2
  } ni_state_e;

  function automatic logic [PAYLOAD_W-1:0] head_payload(
    input logic [ADDR_W-1:0] dest,
    input logic [ADDR_W-1:0] src,
    input logic [LEN_W-1:0]  len
  );
    logic [PAYLOAD_W-1:0] p;
    p = '0;
    p[HDR_DEST_LSB +: ADDR_W] = dest;
    p[HDR_SRC_LSB  +: ADDR_W] = src;
    p[HDR_LEN_LSB  +: LEN_W]  = len;
    return p;
  endfunction

  function automatic logic [FLIT_W-1:0] make_flit(
    input logic                 head,
    input logic                 tail,
    input logic                 vc,
    input logic [PAYLOAD_W-1:0] payload
  );
    logic [FLIT_W-1:0] f;
    f = '0;
    f[FLIT_VALID] = 1'b1;
    f[FLIT_HEAD]  = head;
    f[FLIT_TAIL]  = tail;
    f[FLIT_VC]    = vc;
    f[FLIT_PAYLOAD_LSB +: PAYLOAD_W] = payload;
    return f;
  endfunction

endpackage

// File: rtl/router_ni_credit_ctr.sv
// Per-VC credit counter: starts full, saturates at CREDITS and flags an
// overflow (sticky) when a credit comes back to an already-full counter.
module router_ni_credit_ctr #(
  parameter int CREDITS = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic has_credit,
  output logic overflow
);

  localparam logic [3:0] MAX_CREDIT = 4'(CREDITS);

  logic [3:0] count_r;
  logic       overflow_r;

  // Credit count and sticky overflow; return and consume together cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r    <= MAX_CREDIT;
      overflow_r <= 1'b0;
    end else begin
      case ({inc, dec})
        2'b10: begin
          if (count_r == MAX_CREDIT) begin
            overflow_r <= 1'b1;
          end else begin
            count_r <= count_r + 4'd1;
          end
        end
        2'b01: begin
          if (count_r != 4'd0) begin
            count_r <= count_r - 4'd1;
          end else begin
            count_r <= count_r;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  assign has_credit = (count_r != 4'd0);
  assign overflow   = overflow_r;

endmodule

// File: rtl/router_inject_ni.sv
// Local-port injection network interface: turns packet requests plus body
// payloads into head/body/tail flits, alternating VCs and honouring credits.
module router_inject_ni
  import router_ni_pkg::*;
#(
  parameter int CREDITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    router_address,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_W-1:0]    req_dest,
  input  logic [LEN_W-1:0]     req_len,
  input  logic                 data_valid,
  output logic                 data_ready,
  input  logic [PAYLOAD_W-1:0] data,
  output logic [FLIT_W-1:0]    channel_out,
  input  logic [1:0]           flow_ctrl_in,
  output logic                 error,
  output logic                 busy
);

  ni_state_e            state_r, state_nxt_s;
  logic                 vc_r, vc_nxt_s;
  logic                 last_vc_r, last_vc_nxt_s;
  logic [ADDR_W-1:0]    dest_r, dest_nxt_s;
  logic [LEN_W-1:0]     len_r, len_nxt_s;
  logic [LEN_W-1:0]     cnt_r, cnt_nxt_s;
  logic [FLIT_W-1:0]    flit_r, flit_nxt_s;
  logic                 consume_s;
  logic                 req_ready_s;
  logic                 data_ready_s;
  logic                 body_tail_s;
  logic                 cur_credit_s;
  logic [NUM_VC-1:0]    has_credit_s;
  logic [NUM_VC-1:0]    overflow_s;
  logic [NUM_VC-1:0]    ret_s;
  logic [NUM_VC-1:0]    use_s;

  assign cur_credit_s = has_credit_s[vc_r];
  assign body_tail_s  = (4'(cnt_r + 4'd1) == len_r);

  // Next-state, handshake readies and the flit to be registered this cycle.
  always_comb begin
    state_nxt_s   = state_r;
    vc_nxt_s      = vc_r;
    last_vc_nxt_s = last_vc_r;
    dest_nxt_s    = dest_r;
    len_nxt_s     = len_r;
    cnt_nxt_s     = cnt_r;
    flit_nxt_s    = '0;
    consume_s     = 1'b0;
    req_ready_s   = 1'b0;
    data_ready_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        req_ready_s = 1'b1;
        if (req_valid) begin
          dest_nxt_s    = req_dest;
          len_nxt_s     = req_len;
          vc_nxt_s      = ~last_vc_r;
          last_vc_nxt_s = ~last_vc_r;
          state_nxt_s   = ST_HEAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HEAD: begin
        if (cur_credit_s) begin
          consume_s  = 1'b1;
          flit_nxt_s = make_flit(1'b1, (len_r == 4'd0), vc_r,
                                 head_payload(dest_r, router_address, len_r));
          cnt_nxt_s  = 4'd0;
          if (len_r == 4'd0) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_BODY;
          end
        end else begin
          state_nxt_s = ST_HEAD;
        end
      end
      ST_BODY: begin
        data_ready_s = cur_credit_s;
        if (data_valid && cur_credit_s) begin
          consume_s  = 1'b1;
          flit_nxt_s = make_flit(1'b0, body_tail_s, vc_r, data);
          cnt_nxt_s  = 4'(cnt_r + 4'd1);
          if (body_tail_s) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_BODY;
          end
        end else begin
          state_nxt_s = ST_BODY;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Packet context, VC alternation and the registered output flit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      vc_r      <= 1'b0;
      last_vc_r <= 1'b1;
      dest_r    <= '0;
      len_r     <= '0;
      cnt_r     <= '0;
      flit_r    <= '0;
    end else begin
      state_r   <= state_nxt_s;
      vc_r      <= vc_nxt_s;
      last_vc_r <= last_vc_nxt_s;
      dest_r    <= dest_nxt_s;
      len_r     <= len_nxt_s;
      cnt_r     <= cnt_nxt_s;
      flit_r    <= flit_nxt_s;
    end
  end

  assign ret_s[0] = flow_ctrl_in[0] && (flow_ctrl_in[1] == 1'b0);
  assign ret_s[1] = flow_ctrl_in[0] && (flow_ctrl_in[1] == 1'b1);
  assign use_s[0] = consume_s && (vc_r == 1'b0);
  assign use_s[1] = consume_s && (vc_r == 1'b1);

  router_ni_credit_ctr #(.CREDITS(CREDITS)) u_credit_vc0 (
    .clk        (clk),
    .reset      (reset),
    .inc        (ret_s[0]),
    .dec        (use_s[0]),
    .has_credit (has_credit_s[0]),
    .overflow   (overflow_s[0])
  );

  router_ni_credit_ctr #(.CREDITS(CREDITS)) u_credit_vc1 (
    .clk        (clk),
    .reset      (reset),
    .inc        (ret_s[1]),
    .dec        (use_s[1]),
    .has_credit (has_credit_s[1]),
    .overflow   (overflow_s[1])
  );

  assign req_ready   = req_ready_s;
  assign data_ready  = data_ready_s;
  assign channel_out = flit_r;
  assign error       = |overflow_s;
  assign busy        = (state_r != ST_IDLE);

endmodule

// File: tb/tb_router_inject_ni.sv
// Randomised bench for router_inject_ni against a packet-level model, with
// directed literal checks for the documented scenarios.
module tb_router_inject_ni;

  localparam int TB_CREDITS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  router_address;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_dest;
  logic [3:0]  req_len;
  logic        data_valid;
  logic        data_ready;
  logic [63:0] data;
  logic [67:0] channel_out;
  logic [1:0]  flow_ctrl_in;
  logic        error;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Packet-level model state
  bit          m_open;
  bit          m_head_pend;
  int          m_left;
  bit          m_vc;
  bit          m_next_vc;
  int          m_credit[2];
  bit          m_err;
  logic [5:0]  m_dest;
  logic [3:0]  m_len;
  logic [67:0] m_flit;

  router_inject_ni #(.CREDITS(TB_CREDITS)) dut (
    .clk            (clk),
    .reset          (reset),
    .router_address (router_address),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_dest       (req_dest),
    .req_len        (req_len),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
    .data           (data),
    .channel_out    (channel_out),
    .flow_ctrl_in   (flow_ctrl_in),
    .error          (error),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_open      = 1'b0;
    m_head_pend = 1'b0;
    m_left      = 0;
    m_vc        = 1'b0;
    m_next_vc   = 1'b0;
    m_credit[0] = TB_CREDITS;
    m_credit[1] = TB_CREDITS;
    m_err       = 1'b0;
    m_flit      = '0;
  endtask

  // Apply current inputs to the model, advance one clock, compare every output.
  task automatic tick();
    bit          consume;
    logic [63:0] pl;
    bit          inc, dec;
    consume = 1'b0;
    m_flit  = '0;
    if (!m_open) begin
      if (req_valid) begin
        m_open      = 1'b1;
        m_head_pend = 1'b1;
        m_left      = int'(req_len);
        m_dest      = req_dest;
        m_len       = req_len;
        m_vc        = m_next_vc;
        m_next_vc   = !m_next_vc;
      end
    end else if (m_head_pend) begin
      if (m_credit[m_vc] > 0) begin
        consume     = 1'b1;
        m_head_pend = 1'b0;
        pl          = {48'd0, m_len, router_address, m_dest};
        m_flit      = {pl, m_vc, (m_left == 0), 1'b1, 1'b1};
        if (m_left == 0) m_open = 1'b0;
      end
    end else if (data_valid && m_credit[m_vc] > 0) begin
      consume = 1'b1;
      m_left  = m_left - 1;
      m_flit  = {data, m_vc, (m_left == 0), 1'b0, 1'b1};
      if (m_left == 0) m_open = 1'b0;
    end
    for (int v = 0; v < 2; v++) begin
      inc = flow_ctrl_in[0] && (int'(flow_ctrl_in[1]) == v);
      dec = consume && (int'(m_vc) == v);
      if (inc && !dec) begin
        if (m_credit[v] == TB_CREDITS) m_err = 1'b1;
        else m_credit[v] = m_credit[v] + 1;
      end else if (dec && !inc) begin
        m_credit[v] = m_credit[v] - 1;
      end
    end
    @(posedge clk);
    #1;
    check("channel_out", channel_out, m_flit);
    check("error", error, m_err);
    check("busy", busy, m_open);
    check("req_ready", req_ready, !m_open);
    check("data_ready", data_ready, m_open && !m_head_pend && (m_credit[m_vc] > 0));
  endtask

  task automatic rand_inputs(input bit force_req);
    logic v;
    req_valid  = force_req ? 1'b1 : 1'($urandom_range(0, 1));
    req_dest   = 6'($urandom);
    req_len    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
    data_valid = ($urandom_range(0, 9) < 7);
    data       = {$urandom, $urandom};
    v          = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 9) < 4 && m_credit[v] < TB_CREDITS) flow_ctrl_in = {v, 1'b1};
    else flow_ctrl_in = 2'b00;
  endtask

  initial begin
    bit found;
    reset          = 1'b1;
    router_address = 6'h12;
    req_valid      = 1'b0;
    req_dest       = 6'h00;
    req_len        = 4'h0;
    data_valid     = 1'b0;
    data           = 64'h0;
    flow_ctrl_in   = 2'b00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_channel_out", channel_out, 68'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_error", error, 1'b0);
    reset = 1'b0;
    check("rst_req_ready", req_ready, 1'b1);

    // Single head/tail packet
    req_valid = 1'b1; req_dest = 6'h05; req_len = 4'd0;
    tick();
    req_valid = 1'b0;
    tick();
    check("p1_flags", channel_out[3:0], 4'b0111);
    check("p1_hdr", channel_out[19:4], 16'h0485);

    // len=3 packet on vc1, data offered continuously
    req_valid = 1'b1; req_dest = 6'h07; req_len = 4'd3;
    data_valid = 1'b1; data = 64'hA;
    tick();
    req_valid = 1'b0;
    tick();
    check("p2_head_flags", channel_out[3:0], 4'b1011);
    tick();
    check("p2_body0", channel_out, {64'hA, 4'b1001});
    data = 64'hB;
    tick();
    data = 64'hC;
    tick();
    check("p2_tail", channel_out, {64'hC, 4'b1101});
    check("p2_no_more_data", data_ready, 1'b0);
    data = 64'hD;
    tick();
    check("p2_idle_gap", channel_out, 68'h0);

    // len=3 on vc0 with only 3 credits left: stalls until one returns
    req_valid = 1'b1; req_dest = 6'h09; req_len = 4'd3; data = 64'h1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    data = 64'h2;
    tick();
    check("p3_stall_ready", data_ready, 1'b0);
    data = 64'h3;
    tick();
    check("p3_stall_a", channel_out, 68'h0);
    tick();
    check("p3_stall_b", channel_out, 68'h0);
    flow_ctrl_in = 2'b01;
    tick();
    check("p3_credit_back", data_ready, 1'b1);
    check("p3_no_early", channel_out, 68'h0);
    flow_ctrl_in = 2'b00;
    tick();
    check("p3_tail", channel_out, {64'h3, 4'b0101});
    data_valid = 1'b0;

    for (int v = 0; v < 2; v++) begin
      while (m_credit[v] < TB_CREDITS) begin
        flow_ctrl_in = {1'(v), 1'b1};
        tick();
      end
    end
    flow_ctrl_in = 2'b00;

    // Randomised traffic
    router_address = 6'h2D;
    for (int i = 0; i < 3000; i++) begin
      rand_inputs(1'b0);
      tick();
    end
    req_valid = 1'b0;
    for (int i = 0; i < 500 && m_open; i++) begin
      rand_inputs(1'b0);
      req_valid = 1'b0;
      data_valid = 1'b1;
      tick();
    end
    check("drain_done", m_open, 1'b0);

    // Reset while a body flit is on the channel
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      rand_inputs(1'b1);
      req_len = 4'd8;
      data_valid = 1'b1;
      tick();
      if (m_open && !m_head_pend && m_flit[0]) found = 1'b1;
    end
    check("mid_body_reached", found, 1'b1);
    req_valid = 1'b0; data_valid = 1'b0; flow_ctrl_in = 2'b00;
    #2;
    reset = 1'b1;
    #1;
    check("arst_channel_out", channel_out, 68'h0);
    check("arst_busy", busy, 1'b0);
    check("arst_req_ready", req_ready, 1'b1);
    @(posedge clk);
    #1;
    check("arst_hold", channel_out, 68'h0);
    reset = 1'b0;
    model_reset();

    req_valid = 1'b1; req_dest = 6'h03; req_len = 4'd1;
    tick();
    req_valid = 1'b0;
    tick();
    check("p4_head_vc0", channel_out[3:0], 4'b0011);
    data_valid = 1'b1; data = 64'h55;
    tick();
    check("p4_tail", channel_out, {64'h55, 4'b0101});
    data_valid = 1'b0;

    // Credit return to a full vc1
    flow_ctrl_in = 2'b11;
    tick();
    check("ovf_set", error, 1'b1);
    flow_ctrl_in = 2'b00;
    repeat (3) tick();
    check("ovf_sticky", error, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
